// File: rtl/lcd_write_sequencer_if.sv
// lcd_write_sequencer_if: host byte-write handshake
interface lcd_write_sequencer_if;
  logic       wr_valid;
  logic       wr_rs;
  logic [7:0] wr_data;
  logic       wr_ready;
  modport master (output wr_valid, wr_rs, wr_data, input wr_ready);
  modport slave  (input wr_valid, wr_rs, wr_data, output wr_ready);
endinterface

// File: rtl/lcd_write_sequencer.sv
// lcd_write_sequencer: HD44780 power-on init plus host writes timed from the tick generator; LCD_4BIT_EN selects the 4-bit bus
module lcd_write_sequencer #(
  parameter int TICK_W         = 17,
  parameter int E_SETUP_CYC    = 2,
  parameter int E_HIGH_CYC     = 12,
  parameter int PWR_WAIT_TICKS = 5,
  parameter int CMD_WAIT_TICKS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [TICK_W-1:0]    ticks,
  output logic                 tick_start,
  lcd_write_sequencer_if.slave host,
  output logic                 init_done,
  output logic                 lcd_rs,
  output logic                 lcd_rw,
  output logic                 lcd_e,
  output logic [7:0]           lcd_data
);
  localparam int CMAX = E_SETUP_CYC > E_HIGH_CYC ? (E_SETUP_CYC > 2 ? E_SETUP_CYC : 2)
                                                 : (E_HIGH_CYC > 2 ? E_HIGH_CYC : 2);
  localparam int CW = $clog2(CMAX + 1);
  localparam logic [2:0] PWR_WAIT = 3'd0, SETUP = 3'd1, E_HIGH = 3'd2,
                         E_LOW = 3'd3, WAIT_TICK = 3'd4, READY = 3'd5;
`ifdef LCD_4BIT_EN
  localparam int NSTEP = 8;
  localparam logic [63:0] ROM = 64'h06_01_0C_28_20_30_30_30;
`else
  localparam int NSTEP = 4;
  localparam logic [31:0] ROM = 32'h06_01_0C_38;
`endif
  localparam int SW = $clog2(NSTEP);
  localparam logic [SW-1:0] LAST = SW'(NSTEP - 1);
  localparam logic [CW-1:0] SU_END = CW'(E_SETUP_CYC - 1), EH_END = CW'(E_HIGH_CYC - 1),
                            ARM = CW'(2), CTOP = CW'(CMAX);
  localparam logic [TICK_W-1:0] PW_N = TICK_W'(PWR_WAIT_TICKS), CMD_N = TICK_W'(CMD_WAIT_TICKS);
  logic [2:0]    state, nxt;
  logic [CW-1:0] cnt;
  logic [SW-1:0] step, nstep;
  logic [8:0]    src;
  logic          armed, su_done, eh_done, ld, split;
`ifdef LCD_4BIT_EN
  logic [3:0]    lo;
`else
  assign split = 1'b0;
`endif
  assign lcd_rw = 1'b0;
  // next state and the byte to present on the next entry to SETUP
  always_comb begin
    armed   = cnt >= ARM;
    su_done = cnt == SU_END;
    eh_done = cnt == EH_END;
    nstep   = state == PWR_WAIT ? '0 : step + 1'b1;
    src     = state == READY ? {host.wr_rs, host.wr_data} : {1'b0, ROM[{nstep, 3'b000} +: 8]};
    nxt     = state == PWR_WAIT  ? (armed && ticks >= PW_N ? SETUP : PWR_WAIT)
            : state == SETUP     ? (su_done ? E_HIGH : SETUP)
            : state == E_HIGH    ? (eh_done ? E_LOW : E_HIGH)
            : state == E_LOW     ? (eh_done ? (split ? SETUP : WAIT_TICK) : E_LOW)
            : state == WAIT_TICK ? (armed && ticks >= CMD_N ? (init_done || step == LAST ? READY : SETUP) : WAIT_TICK)
            : host.wr_valid      ? SETUP : READY;
    ld      = nxt == SETUP && state != SETUP;
  end
  // sequencer registers; every output is a decode of the next state or a load on SETUP entry
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= PWR_WAIT;
      cnt           <= '0;
      step          <= '0;
      tick_start    <= 1'b0;
      host.wr_ready <= 1'b0;
      init_done     <= 1'b0;
      lcd_rs        <= 1'b0;
      lcd_e         <= 1'b0;
      lcd_data      <= '0;
`ifdef LCD_4BIT_EN
      split         <= 1'b0;
      lo            <= '0;
`endif
    end else begin
      state         <= nxt;
      cnt           <= nxt != state ? '0 : cnt + CW'(cnt != CTOP);
      tick_start    <= nxt == PWR_WAIT || nxt == WAIT_TICK;
      host.wr_ready <= nxt == READY;
      lcd_e         <= nxt == E_HIGH;
      init_done     <= init_done || (state == WAIT_TICK && nxt == READY);
      if (ld && (state == PWR_WAIT || state == WAIT_TICK)) step <= nstep;
`ifdef LCD_4BIT_EN
      if (ld && state == E_LOW) begin
        lcd_data <= {lo, 4'h0};
        split    <= 1'b0;
      end else if (ld) begin
        lcd_rs   <= src[8];
        lcd_data <= {src[7:4], 4'h0};
        lo       <= src[3:0];
        split    <= state == READY || nstep[SW-1];
      end
`else
      if (ld) begin
        lcd_rs   <= src[8];
        lcd_data <= src[7:0];
      end
`endif
    end
  end
endmodule

// File: tb/tb_lcd_write_sequencer.sv
// tb_lcd_write_sequencer: scoreboard bench with a modelled tick generator
module tb_lcd_write_sequencer;
  logic        clk = 1'b0;
  logic        rst;
  logic [16:0] ticks = '0;
  logic [3:0]  div = '0;
  logic        tick_start, init_done, lcd_rs, lcd_rw, lcd_e;
  logic [7:0]  lcd_data;
  lcd_write_sequencer_if host();
  lcd_write_sequencer dut (
    .clk(clk), .rst(rst), .ticks(ticks), .tick_start(tick_start), .host(host),
    .init_done(init_done), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_e(lcd_e), .lcd_data(lcd_data)
  );
  always #20 clk = ~clk;
  // tick generator model: cleared while start is low, one tick per 10 cycles, saturating
  always @(posedge clk) begin
    if (tick_start !== 1'b1) begin
      ticks <= '0;
      div   <= '0;
    end else if (div == 4'd9) begin
      div <= '0;
      if (ticks != 17'd96000) ticks <= ticks + 17'd1;
    end else div <= div + 4'd1;
  end
  int checks = 0, errors = 0;
  logic [8:0] exp_q[$];
  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, req);
    end
  endtask
  task automatic push_first(input logic rs, input logic [7:0] b);
`ifdef LCD_4BIT_EN
    exp_q.push_back({rs, b[7:4], 4'h0});
`else
    exp_q.push_back({rs, b});
`endif
  endtask
  task automatic push_byte(input logic rs, input logic [7:0] b);
    push_first(rs, b);
`ifdef LCD_4BIT_EN
    exp_q.push_back({rs, b[3:0], 4'h0});
`endif
  endtask
  task automatic push_init();
`ifdef LCD_4BIT_EN
    push_first(1'b0, 8'h30);
    push_first(1'b0, 8'h30);
    push_first(1'b0, 8'h30);
    push_first(1'b0, 8'h20);
    push_byte(1'b0, 8'h28);
`else
    push_byte(1'b0, 8'h38);
`endif
    push_byte(1'b0, 8'h0C);
    push_byte(1'b0, 8'h01);
    push_byte(1'b0, 8'h06);
  endtask
  // monitor: pops the scoreboard on every E rise and checks E timing
  logic       prev_e = 1'b0, first = 1'b1, in_pulse = 1'b0, fall_pend = 1'b0;
  logic [8:0] prev_bus = '0, exp;
  int         cyc = 0, stab = 0, hi = 0, since_fall = 0;
  always @(negedge clk) begin
    if (rst) begin
      cyc = 0; stab = 0; first = 1'b1; in_pulse = 1'b0; fall_pend = 1'b0;
    end else begin
      cyc++;
      if (fall_pend) since_fall++;
      if ({lcd_rs, lcd_data} != prev_bus) begin
        if (fall_pend) chk("hold_after_fall", int'(since_fall >= 13), 1);
        fall_pend = 1'b0;
        stab = 1;
      end else stab++;
      if (lcd_e && !prev_e) begin
        chk("setup_stable", int'(stab >= 3), 1);
        if (first) chk("pwr_wait_window", int'(cyc >= 50 && cyc <= 60), 1);
        first = 1'b0;
        chk("lcd_rw", lcd_rw, 0);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL pulse_unexpected got %0h want none", {lcd_rs, lcd_data});
        end else begin
          exp = exp_q.pop_front();
          chk("pulse_bus", {lcd_rs, lcd_data}, exp);
        end
        hi = 1;
        in_pulse = 1'b1;
      end else if (lcd_e && in_pulse) hi++;
      else if (!lcd_e && prev_e && in_pulse) begin
        chk("e_high_len", hi, 12);
        in_pulse = 1'b0;
        fall_pend = 1'b1;
        since_fall = 1;
      end
    end
    prev_e = lcd_e;
    prev_bus = {lcd_rs, lcd_data};
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  logic        ts_seen;
  logic [16:0] tmax;
  task automatic wait_ready(input string name, input int lim);
    logic ok = 1'b0;
    ts_seen = 1'b0;
    tmax = '0;
    for (int i = 0; i < lim && !ok; i++) begin
      @(negedge clk);
      if (tick_start) ts_seen = 1'b1;
      if (ticks > tmax) tmax = ticks;
      ok = host.wr_ready;
    end
    chk(name, ok, 1);
  endtask
  initial begin
    logic ok;
    rst = 1'b1;
    host.wr_valid = 1'b0;
    host.wr_rs = 1'b0;
    host.wr_data = '0;
    repeat (3) step();
    @(negedge clk);
    chk("reset_outputs", {tick_start, host.wr_ready, init_done, lcd_rs, lcd_rw, lcd_e, lcd_data}, 0);
    push_init();
    push_byte(1'b1, 8'h55);
    host.wr_valid = 1'b1;
    host.wr_rs = 1'b1;
    host.wr_data = 8'h55;
    step();
    rst = 1'b0;
    wait_ready("init_ready_timeout", 4000);
    chk("init_done", init_done, 1);
`ifdef LCD_4BIT_EN
    chk("init_pulses_before_ready", exp_q.size(), 2);
`else
    chk("init_pulses_before_ready", exp_q.size(), 1);
`endif
    step();
    host.wr_valid = 1'b0;
    @(negedge clk);
    chk("ready_drop_55", host.wr_ready, 0);
    wait_ready("write55_timeout", 1000);
    chk("write55_done", exp_q.size(), 0);
    chk("tick_start_seen_55", ts_seen, 1);
    push_byte(1'b1, 8'h41);
    step();
    host.wr_valid = 1'b1;
    host.wr_rs = 1'b1;
    host.wr_data = 8'h41;
    step();
    host.wr_valid = 1'b0;
    @(negedge clk);
    chk("ready_drop_41", host.wr_ready, 0);
    wait_ready("write41_timeout", 1000);
    chk("write41_done", exp_q.size(), 0);
    chk("tick_start_seen_41", ts_seen, 1);
    chk("ticks_reached_41", int'(tmax >= 17'd1), 1);
    push_first(1'b0, 8'h33);
    step();
    host.wr_valid = 1'b1;
    host.wr_rs = 1'b0;
    host.wr_data = 8'h33;
    step();
    host.wr_valid = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      ok = lcd_e;
    end
    chk("e_rise_timeout", ok, 1);
    step();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midreset_e", lcd_e, 0);
    chk("midreset_tick_start", tick_start, 0);
    chk("midreset_init_done", init_done, 0);
    repeat (2) step();
    push_init();
    rst = 1'b0;
    wait_ready("reinit_ready_timeout", 4000);
    chk("reinit_done", init_done, 1);
    chk("reinit_all_pulses", exp_q.size(), 0);
    repeat (20) step();
    chk("no_extra_pulses", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/lcd_write_sequencer.md
Name: lcd_write_sequencer

Overview:
- Sits directly downstream of the LCD tick generator. It drives that generator's start input and consumes its 17-bit ticks count (one tick = 10 ms at 25 MHz / 100 Hz) as the time base for HD44780-style waits.
- Runs the power-on init sequence, then accepts command or character bytes through a valid/ready port.
- Drives the LCD pins rs, rw, e and data[7:0], with sub-microsecond E timing counted locally in clk cycles.

Parameters:
- TICK_W, 17, width of ticks input.
- E_SETUP_CYC, 2, clk cycles rs/data are stable before E rises (tAS ≥ 40 ns).
- E_HIGH_CYC, 12, clk cycles E held high; also the E-low gap between nibbles (480 ns).
- PWR_WAIT_TICKS, 5, ticks waited after reset before the first write (50 ms).
- CMD_WAIT_TICKS, 1, ticks waited after every write (10 ms; covers the 1.52 ms clear).

Ports:
- clk  in  1  system clock, 25 MHz
- rst  in  1  synchronous, active-high reset
- ticks  in  TICK_W  tick count from the tick generator
- tick_start  out  1  start/enable to the tick generator; low clears its count
- wr_valid  in  1  host write request
- wr_rs  in  1  0 = command, 1 = data
- wr_data  in  8  byte to write
- wr_ready  out  1  high only in READY
- init_done  out  1  set once init completes; sticky until rst
- lcd_rs  out  1  LCD register select
- lcd_rw  out  1  constant 0
- lcd_e  out  1  LCD enable strobe
- lcd_data  out  8  LCD data bus

Behaviour:
- Reset state: all outputs 0; state PWR_WAIT; init step index 0. rst mid-operation drops lcd_e low on that edge and restarts the init sequence from scratch.
- All outputs are registered.
- States: PWR_WAIT, SETUP, E_HIGH, E_LOW, WAIT_TICK, READY.
- tick_start rule:
  - 1 only in PWR_WAIT and WAIT_TICK; 0 in every other state.
  - The generator is therefore cleared to 0 before every wait, and each wait compares absolute ticks ≥ N.
- Wait arming: the first 2 cycles in PWR_WAIT/WAIT_TICK ignore ticks, because the generator output lags start by one register. From cycle 3 on, exit when ticks ≥ N.
  - PWR_WAIT: N = PWR_WAIT_TICKS, then go to SETUP with init step 0.
  - WAIT_TICK: N = CMD_WAIT_TICKS.
- Init sequence (8-bit): 0x38, 0x0C, 0x01, 0x06, all with rs = 0. After each byte's WAIT_TICK, the next byte is issued. After the last byte: init_done = 1, go to READY.
- Write cycle:
  - SETUP: present lcd_rs/lcd_data for E_SETUP_CYC cycles.
  - E_HIGH: lcd_e = 1 for E_HIGH_CYC cycles.
  - E_LOW: lcd_e = 0 for E_HIGH_CYC cycles, with lcd_rs/lcd_data held.
  - Then go to WAIT_TICK.
- READY: wr_ready = 1. On wr_valid & wr_ready, capture wr_rs/wr_data the same edge, wr_ready → 0 next cycle, go to SETUP.
  - wr_valid outside READY is ignored (no capture, no queue).
  - The host must hold the request until ready.
- Data stability: lcd_data/lcd_rs change only on entry to SETUP.
- Counter widths: the local cycle counter is sized for max(E_SETUP_CYC, E_HIGH_CYC). The tick comparison is unsigned at TICK_W bits.
- Saturated ticks input (96000) still satisfies any N ≤ 96000. No wrap occurs because every wait starts from a cleared generator.

Optional Feature:
- Macro: LCD_4BIT_EN.
- Defined:
  - The bus uses lcd_data[7:4]; lcd_data[3:0] is driven 0.
  - Init prefix: single-nibble writes 0x3, 0x3, 0x3, 0x2, each a full SETUP/E_HIGH/E_LOW/WAIT_TICK cycle.
  - Then bytes 0x28, 0x0C, 0x01, 0x06.
  - Each byte (init or host) is sent high nibble then low nibble. The two nibbles are separated only by E_LOW (no tick wait); WAIT_TICK follows the low nibble only.
- Undefined: 8-bit behaviour as above.

Test Plan:
- Bench models the generator: ticks = 0 while start low; otherwise increments every K cycles.
- Power-on: rst 3 cycles, ticks modelled with K = 10 → no lcd_e pulse before ticks reaches 5; first pulse carries lcd_data = 0x38, rs = 0; then 0x0C, 0x01, 0x06 in order; init_done = 1 and wr_ready = 1 after the 4th WAIT_TICK.
- E timing: measure any pulse → lcd_data stable ≥ 2 cycles before lcd_e rises; lcd_e high exactly 12 cycles; data unchanged for 12 cycles after fall.
- Host write: in READY, wr_valid = 1, wr_rs = 1, wr_data = 0x41 → wr_ready = 0 next cycle, one pulse with rs = 1 and data 0x41, tick_start high during the wait, wr_ready = 1 once ticks ≥ 1.
- Ignored request: hold wr_valid = 1 with wr_data = 0x55 during init → no extra pulse during init; 0x55 is written exactly once after READY.
- Reset mid-write: assert rst while lcd_e = 1 → lcd_e = 0, tick_start = 0, init_done = 0 the next cycle; the full init sequence repeats.
- LCD_4BIT_EN: after reset → nibbles 0x3, 0x3, 0x3, 0x2, then 0x2/0x8, 0x0/0xC, 0x0/0x1, 0x0/0x6 on [7:4], with [3:0] = 0; host byte 0x41 → nibbles 0x4 then 0x1 with no tick wait between them.
